// File: rtl/q_frag_seq_pkg.sv
// Shared types for the Q_FRAG bank sequencer: operation codes, FSM states and
// the request record captured from the winning requester.
package q_frag_seq_pkg;

    localparam int Q_WIDTH = 8;
    localparam int Q_AW    = 2;

    typedef enum logic [1:0] {
        OP_WRITE      = 2'b00,
        OP_CLEAR_ALL  = 2'b01,
        OP_PRESET_ALL = 2'b10,
        OP_NOP        = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_IDLE,
        ST_EXEC,
        ST_SETTLE
    } state_t;

    // Sized by the package geometry; narrower instances zero-extend into it.
    typedef struct packed {
        op_t                op;
        logic [Q_AW-1:0]    addr;
        logic [Q_WIDTH-1:0] data;
    } req_t;

endpackage

// File: rtl/q_frag_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers who won last and only
// moves when a grant is actually issued.
module q_frag_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       en,
    output logic [1:0] grant
);

    logic last_b;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_b ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Starting as "B won last" makes the first contested grant go to A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b <= 1'b1;
        end else if (|grant) begin
            last_b <= grant[1];
        end
    end

endmodule

// File: rtl/q_frag_seq.sv
// Sequencer for a Q_FRAG flip-flop bank: power-up reset hold, then arbitrated
// write / clear-all / preset-all operations as accept, execute, settle steps.
module q_frag_seq
    import q_frag_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AW       = 2,
    parameter int HOLD_CYC = 4
) (
    input  logic             QCK,
    input  logic             QRST_N,
    input  logic             a_valid,
    input  logic             b_valid,
    output logic             a_ready,
    output logic             b_ready,
    input  logic [1:0]       a_op,
    input  logic [1:0]       b_op,
    input  logic [AW-1:0]    a_addr,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] a_data,
    input  logic [WIDTH-1:0] b_data,
    output logic [DEPTH-1:0] qen,
    output logic [WIDTH-1:0] qdi,
    output logic             cds,
    output logic             qrt,
    output logic             qst,
    output logic             uqrt,
    output logic             uqst,
    output logic             qrts,
    output logic             qsts,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             err
);

    localparam int             HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [AW:0]    DEPTH_W   = (AW + 1)'(DEPTH);

    state_t             state, state_nxt;
    logic [HW-1:0]      hold_cnt, hold_nxt;
    logic               id_q, id_nxt;
    logic               bad_q, bad_nxt;
    logic [1:0]         grant;
    req_t               sel_req;
    logic               sel_bad;
    logic [AW-1:0]      sel_addr;

    logic [DEPTH-1:0]   qen_nxt;
    logic [WIDTH-1:0]   qdi_nxt;
    logic               cds_nxt, qrt_nxt, uqrt_nxt, uqst_nxt, sel_nxt;
    logic               busy_nxt, done_nxt, done_id_nxt, err_nxt;
    logic               sel_q;

    q_frag_rr_arb2 u_arb (
        .clk   (QCK),
        .rst_n (QRST_N),
        .valid ({b_valid, a_valid}),
        .en    (state == ST_IDLE),
        .grant (grant)
    );

    assign a_ready = grant[0];
    assign b_ready = grant[1];
    assign qrts    = sel_q;
    assign qsts    = sel_q;
    assign qst     = 1'b0;

    always_comb begin
        if (grant[1]) begin
            sel_req.op   = op_t'(b_op);
            sel_req.addr = Q_AW'(b_addr);
            sel_req.data = Q_WIDTH'(b_data);
        end else begin
            sel_req.op   = op_t'(a_op);
            sel_req.addr = Q_AW'(a_addr);
            sel_req.data = Q_WIDTH'(a_data);
        end
        sel_addr = AW'(sel_req.addr);
        sel_bad  = (sel_req.op == OP_WRITE) && ({1'b0, sel_addr} >= DEPTH_W);
    end

    // Outputs are computed for the coming state so every pin leaves a flop;
    // strobes for an operation are launched on the accept edge itself.
    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        id_nxt      = id_q;
        bad_nxt     = bad_q;
        qen_nxt     = '0;
        qdi_nxt     = qdi;
        cds_nxt     = 1'b0;
        qrt_nxt     = 1'b0;
        uqrt_nxt    = 1'b0;
        uqst_nxt    = 1'b0;
        sel_nxt     = 1'b1;
        done_nxt    = 1'b0;
        done_id_nxt = done_id;
        err_nxt     = 1'b0;

        case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                    qrt_nxt  = 1'b1;
                    sel_nxt  = 1'b0;
                end
            end
            ST_IDLE: begin
                if (|grant) begin
                    state_nxt = ST_EXEC;
                    id_nxt    = grant[1];
                    bad_nxt   = sel_bad;
                    case (sel_req.op)
                        OP_WRITE: begin
                            if (!sel_bad) begin
                                qen_nxt = DEPTH'(1) << sel_addr;
                                cds_nxt = 1'b1;
                                qdi_nxt = WIDTH'(sel_req.data);
                            end
                        end
                        OP_CLEAR_ALL:  uqrt_nxt = 1'b1;
                        OP_PRESET_ALL: uqst_nxt = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_EXEC: begin
                state_nxt   = ST_SETTLE;
                done_nxt    = 1'b1;
                done_id_nxt = id_q;
                err_nxt     = bad_q;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge QCK or negedge QRST_N) begin
        if (!QRST_N) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
            id_q     <= 1'b0;
            bad_q    <= 1'b0;
            qen      <= '0;
            qdi      <= '0;
            cds      <= 1'b0;
            qrt      <= 1'b1;
            uqrt     <= 1'b0;
            uqst     <= 1'b0;
            sel_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            done_id  <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            id_q     <= id_nxt;
            bad_q    <= bad_nxt;
            qen      <= qen_nxt;
            qdi      <= qdi_nxt;
            cds      <= cds_nxt;
            qrt      <= qrt_nxt;
            uqrt     <= uqrt_nxt;
            uqst     <= uqst_nxt;
            sel_q    <= sel_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            done_id  <= done_id_nxt;
            err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_q_frag_seq.sv
// Bench for q_frag_seq: directed scenarios plus random traffic, all checked
// every cycle against a timestamp-based scheduling model of the sequencer.
module tb_q_frag_seq;
    import q_frag_seq_pkg::*;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 3;
    localparam int AW       = 2;
    localparam int HOLD_CYC = 4;

    logic             QCK = 1'b0;
    logic             QRST_N = 1'b0;
    logic             a_valid = 1'b0, b_valid = 1'b0;
    logic             a_ready, b_ready;
    logic [1:0]       a_op = 2'b11, b_op = 2'b11;
    logic [AW-1:0]    a_addr = '0, b_addr = '0;
    logic [WIDTH-1:0] a_data = '0, b_data = '0;
    logic [DEPTH-1:0] qen;
    logic [WIDTH-1:0] qdi;
    logic             cds, qrt, qst, uqrt, uqst, qrts, qsts;
    logic             busy, done, done_id, err;

    int total = 0;
    int bad   = 0;

    // Model: c counts clock edges since reset release; an op accepted at the
    // end of cycle c executes in c+1, reports in c+2, and frees the bank at c+3.
    int               c, free_at, exec_c, done_c;
    bit               last_b, pend_id, pend_err, model_done_id;
    logic [DEPTH-1:0] exp_qen;
    bit               exp_cds, exp_uqrt, exp_uqst;
    logic [WIDTH-1:0] model_qdi;
    int               a_repeat = 0, b_repeat = 0;
    bit               rand_mode = 1'b0;

    always #5 QCK = ~QCK;

    q_frag_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .HOLD_CYC(HOLD_CYC)) dut (
        .QCK(QCK), .QRST_N(QRST_N),
        .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
        .a_op(a_op), .b_op(b_op), .a_addr(a_addr), .b_addr(b_addr),
        .a_data(a_data), .b_data(b_data),
        .qen(qen), .qdi(qdi), .cds(cds), .qrt(qrt), .qst(qst),
        .uqrt(uqrt), .uqst(uqst), .qrts(qrts), .qsts(qsts),
        .busy(busy), .done(done), .done_id(done_id), .err(err)
    );

    function automatic logic [1:0] who_wins(input logic av, input logic bv, input bit lb);
        if (av && bv) return lb ? 2'b01 : 2'b10;
        return {bv, av};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, c);
        end
    endtask

    task automatic model_reset();
        c = 0; free_at = HOLD_CYC; exec_c = -1; done_c = -1;
        last_b = 1'b1; pend_id = 1'b0; pend_err = 1'b0;
        model_done_id = 1'b0; model_qdi = '0;
        exp_qen = '0; exp_cds = 1'b0; exp_uqrt = 1'b0; exp_uqst = 1'b0;
    endtask

    task automatic check_reset_values();
        check_val("rst_qrt", 32'(qrt), 1);       check_val("rst_qrts", 32'(qrts), 0);
        check_val("rst_qsts", 32'(qsts), 0);     check_val("rst_qst", 32'(qst), 0);
        check_val("rst_qen", 32'(qen), 0);       check_val("rst_cds", 32'(cds), 0);
        check_val("rst_uqrt", 32'(uqrt), 0);     check_val("rst_uqst", 32'(uqst), 0);
        check_val("rst_busy", 32'(busy), 0);     check_val("rst_done", 32'(done), 0);
        check_val("rst_err", 32'(err), 0);       check_val("rst_qdi", 32'(qdi), 0);
        check_val("rst_done_id", 32'(done_id), 0);
        check_val("rst_a_ready", 32'(a_ready), 0);
        check_val("rst_b_ready", 32'(b_ready), 0);
    endtask

    task automatic check_output();
        logic [1:0] g;
        bit idle, in_exec, in_done;
        idle    = (c >= free_at);
        in_exec = (c == exec_c);
        in_done = (c == done_c);
        g = idle ? who_wins(a_valid, b_valid, last_b) : 2'b00;
        check_val("a_ready", 32'(a_ready), 32'(g[0]));
        check_val("b_ready", 32'(b_ready), 32'(g[1]));
        check_val("qen", 32'(qen), in_exec ? 32'(exp_qen) : 0);
        check_val("cds", 32'(cds), 32'(in_exec && exp_cds));
        check_val("uqrt", 32'(uqrt), 32'(in_exec && exp_uqrt));
        check_val("uqst", 32'(uqst), 32'(in_exec && exp_uqst));
        check_val("qdi", 32'(qdi), 32'(model_qdi));
        check_val("qrt", 32'(qrt), 32'(c < HOLD_CYC));
        check_val("qrts", 32'(qrts), 32'(c >= HOLD_CYC));
        check_val("qsts", 32'(qsts), 32'(c >= HOLD_CYC));
        check_val("qst", 32'(qst), 0);
        check_val("busy", 32'(busy), (c == 0) ? 0 : 32'(!idle));
        check_val("done", 32'(done), 32'(in_done));
        check_val("done_id", 32'(done_id), 32'(model_done_id));
        check_val("err", 32'(err), 32'(in_done && pend_err));
    endtask

    task automatic model_edge(output bit acc_a, output bit acc_b);
        logic [1:0]       g;
        logic [1:0]       opv;
        logic [AW-1:0]    ad;
        logic [WIDTH-1:0] d;
        g = (c >= free_at) ? who_wins(a_valid, b_valid, last_b) : 2'b00;
        acc_a = g[0];
        acc_b = g[1];
        if (g != 2'b00) begin
            opv = g[1] ? b_op : a_op;
            ad  = g[1] ? b_addr : a_addr;
            d   = g[1] ? b_data : a_data;
            last_b = g[1]; pend_id = g[1];
            exec_c = c + 1; done_c = c + 2; free_at = c + 3;
            exp_qen = '0; exp_cds = 1'b0; exp_uqrt = 1'b0; exp_uqst = 1'b0; pend_err = 1'b0;
            case (op_t'(opv))
                OP_WRITE: begin
                    if (int'(ad) < DEPTH) begin
                        exp_qen   = DEPTH'(1 << ad);
                        exp_cds   = 1'b1;
                        model_qdi = d;
                    end else begin
                        pend_err = 1'b1;
                    end
                end
                OP_CLEAR_ALL:  exp_uqrt = 1'b1;
                OP_PRESET_ALL: exp_uqst = 1'b1;
                default: ;
            endcase
        end
        c++;
        if (c == done_c) model_done_id = pend_id;
    endtask

    task automatic post_a(input logic [1:0] op, input logic [AW-1:0] ad, input logic [WIDTH-1:0] d, input int rep);
        a_valid = 1'b1; a_op = op; a_addr = ad; a_data = d; a_repeat = rep;
    endtask

    task automatic post_b(input logic [1:0] op, input logic [AW-1:0] ad, input logic [WIDTH-1:0] d, input int rep);
        b_valid = 1'b1; b_op = op; b_addr = ad; b_data = d; b_repeat = rep;
    endtask

    task automatic apply_stimulus(input bit acc_a, input bit acc_b);
        if (acc_a) begin
            if (a_repeat > 0) begin a_repeat--; a_data = a_data + 1'b1; end
            else a_valid = 1'b0;
        end
        if (acc_b) begin
            if (b_repeat > 0) begin b_repeat--; b_data = b_data + 1'b1; end
            else b_valid = 1'b0;
        end
        if (rand_mode) begin
            if (!a_valid && $urandom_range(0, 1) == 1)
                post_a(2'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), WIDTH'($urandom_range(0, 255)), 0);
            if (!b_valid && $urandom_range(0, 1) == 1)
                post_b(2'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), WIDTH'($urandom_range(0, 255)), 0);
        end
    endtask

    task automatic tick();
        bit aa, ab;
        @(negedge QCK);
        check_output();
        @(posedge QCK);
        model_edge(aa, ab);
        #1;
        apply_stimulus(aa, ab);
    endtask

    task automatic run_until_drained(input int budget);
        int n = 0;
        while ((a_valid || b_valid) && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (a_valid || b_valid) begin
            bad++;
            $error("[TB] FAIL drain: requests still pending after %0d cycles, expected none", budget);
            a_valid = 1'b0;
            b_valid = 1'b0;
        end
        repeat (3) tick();
    endtask

    initial begin
        bit aa, ab;
        int n;
        model_reset();
        $display("[TB] power-up reset with A WRITE addr=2 data=A5 already waiting");
        post_a(OP_WRITE, 2'd2, 8'hA5, 0);
        repeat (3) @(posedge QCK);
        @(negedge QCK);
        check_reset_values();
        @(posedge QCK);
        #1;
        QRST_N = 1'b1;
        model_reset();
        run_until_drained(20);

        $display("[TB] A and B contend with held WRITEs");
        post_a(OP_WRITE, 2'd0, 8'h10, 3);
        post_b(OP_WRITE, 2'd1, 8'h20, 3);
        run_until_drained(40);

        $display("[TB] B CLEAR_ALL then A PRESET_ALL");
        post_b(OP_CLEAR_ALL, 2'd0, 8'h00, 0);
        run_until_drained(10);
        post_a(OP_PRESET_ALL, 2'd0, 8'h00, 0);
        run_until_drained(10);

        $display("[TB] out-of-range WRITE and NOP");
        post_a(OP_WRITE, 2'd3, 8'h5A, 0);
        post_b(OP_NOP, 2'd0, 8'h00, 0);
        run_until_drained(15);

        $display("[TB] random traffic");
        rand_mode = 1'b1;
        repeat (400) tick();
        rand_mode = 1'b0;
        run_until_drained(20);

        $display("[TB] reset during EXEC of an A WRITE");
        post_a(OP_WRITE, 2'd1, 8'h3C, 0);
        aa = 1'b0;
        n  = 0;
        while (!aa && n < 10) begin
            @(negedge QCK);
            check_output();
            @(posedge QCK);
            model_edge(aa, ab);
            #1;
            n++;
        end
        check_val("exec_before_reset_qen", 32'(qen), 32'b010);
        QRST_N = 1'b0;
        a_valid = 1'b0;
        #1;
        check_reset_values();
        @(posedge QCK);
        #1;
        check_reset_values();
        QRST_N = 1'b1;
        model_reset();
        post_a(OP_WRITE, 2'd2, 8'hC3, 0);
        post_b(OP_WRITE, 2'd0, 8'h77, 0);
        run_until_drained(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/q_frag_seq.md
# q_frag_seq

Sequencer and two-port arbiter for a bank of Q_FRAG logic-cell flip-flops. It owns every control pin of the bank: QEN, QDI, CDS, the set/reset strobes and the QSTS/QRTS selects. It holds the bank in asynchronous reset after power-up, then serves word-write, clear-all and preset-all requests from two requesters (A, B) through valid/ready handshakes. Each operation is a fixed accept/execute/settle sequence, so set/reset never overlaps a data capture.

## Interface
- WIDTH, 8: bits per word (QDI width).
- DEPTH, 4: words in bank; one QEN line per word.
- AW, 2: address width, must satisfy 2**AW >= DEPTH.
- HOLD_CYC, 4: cycles QRT stays asserted after reset release (>=1).
- QCK  in  1  bank clock; all state on posedge.
- QRST_N  in  1  reset, asynchronous, active-low.
- a_valid, b_valid  in  1  request valid, per requester.
- a_ready, b_ready  out  1  request accepted when valid&ready.
- a_op, b_op  in  2  00 WRITE, 01 CLEAR_ALL, 10 PRESET_ALL, 11 NOP.
- a_addr, b_addr  in  AW  word address (WRITE only).
- a_data, b_data  in  WIDTH  write data (WRITE only).
- qen  out  DEPTH  one-hot word enable to the bank.
- qdi  out  WIDTH  data to the bank.
- cds  out  1  capture-data select.
- qrt, qst  out  1  asynchronous reset/set to the bank.
- uqrt, uqst  out  1  synchronous reset/set to the bank.
- qrts, qsts  out  1  selects: 1 = use uqrt/uqst.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when an operation completes.
- done_id  out  1  requester of the completed op (0 = A, 1 = B).
- err  out  1  pulses with done when a WRITE address is >= DEPTH.

## Operation
- All outputs are registered.
- States: HOLD, IDLE, EXEC, SETTLE.
- Reset values:
  - State HOLD, hold counter 0.
  - qrt=1. qrts=0, qsts=0. All other outputs 0, including ready, busy, done and err.
  - Round-robin pointer favours A.
- HOLD:
  - qrt=1 for HOLD_CYC cycles after QRST_N rises.
  - Then qrt=0 and qrts=qsts=1; go to IDLE.
  - busy=1.
- IDLE:
  - Drives qen=0, cds=0, uqrt=uqst=0, qrts=qsts=1.
  - a_ready/b_ready are combinational from the arbiter. At most one is high, only in IDLE, and only toward a valid requester.
  - Arbitration: if only one requester is valid it is granted. If both are valid, grant goes to the one not granted last. The pointer updates on accept only.
  - On accept, latch op, addr, data and id; go to EXEC.
- EXEC (exactly one cycle):
  - WRITE, addr < DEPTH: qen[addr]=1, cds=1, qdi=data.
  - WRITE, addr >= DEPTH: no strobes; err flagged.
  - CLEAR_ALL: uqrt=1.
  - PRESET_ALL: uqst=1.
  - NOP: no strobes.
  - Go to SETTLE.
- SETTLE (one cycle):
  - All strobes 0, qdi holds its value.
  - done=1, done_id=latched id, err as flagged.
  - Go to IDLE.
- No requester input is sampled outside IDLE; a request held valid waits.
- QRST_N low at any time forces reset values immediately. The in-flight op is dropped with no done.

## Timing
- Accept at edge N. EXEC outputs are valid N..N+1, and the bank captures at edge N+1. done is high during cycle N+2. ready is possible again in cycle N+3.
- Throughput is one operation per 3 cycles; back-to-back A/B requests alternate.
- qrt is the only asynchronous strobe driven; qst is tied 0 after reset.
- Set/reset strobes and cds are never high in the same cycle. qen is never multi-hot.
- First possible accept: cycle HOLD_CYC+1 after reset release.

## Structure
- Package q_frag_seq_pkg holds:
  - op_t enum: WRITE, CLEAR_ALL, PRESET_ALL, NOP.
  - state_t enum: HOLD, IDLE, EXEC, SETTLE.
  - Request struct {op, addr, data}.
- Sub-module q_frag_rr_arb2: 2-way round-robin arbiter with a pointer register, inputs valid[1:0] and en, outputs grant[1:0].
- Hold counter, FSM and output registers live in q_frag_seq.

## Test plan
- Reset release, HOLD_CYC=4 -> qrt=1 for 4 cycles then 0; qrts=qsts=1; a_ready first high in cycle 5.
- A WRITE addr=2 data=0xA5 -> one EXEC cycle with qen=0100, cds=1, qdi=0xA5; done=1, done_id=0 two cycles after accept.
- A and B both valid with WRITE ops held -> grants A, B, A, B; done_id alternates 0,1,0,1; accepts 3 cycles apart.
- B CLEAR_ALL then A PRESET_ALL -> uqrt=1 for one cycle, then later uqst=1 for one cycle; never both high, cds=0 throughout.
- WRITE addr=3 with DEPTH=3 -> qen=0 in EXEC; err=1 coincident with done.
- QRST_N low during EXEC of a WRITE -> qen=0 and qrt=1 immediately; no done; after release, the HOLD sequence repeats and the pointer favours A.
